// File: rtl/dt_pkg.sv
// Shared definitions for the distance-transform core.
// Image geometry, memory address widths and loader states.
package dt_pkg;

  localparam int IMG_W     = 128;
  localparam int IMG_H     = 128;
  localparam int WORD_W    = 16;
  localparam int STI_DEPTH = 1024;
  localparam int RES_DEPTH = 16384;

  localparam int STI_AW = 10;
  localparam int RES_AW = 14;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_FETCH,
    LD_WRITE,
    LD_DONE
  } ld_state_e;

endpackage

// File: rtl/dt_sti_loader.sv
// Unpacks the 1-bit sti ROM image into the byte-per-pixel res RAM.
// One pixel per cycle, with a prefetch that keeps the writes gapless.
module dt_sti_loader
  import dt_pkg::*;
#(
  parameter logic [7:0] OBJ_VAL      = 8'h01,
  parameter logic [7:0] BG_VAL       = 8'h00,
  parameter bit         CLEAR_BORDER = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              sti_rd,
  output logic [STI_AW-1:0] sti_addr,
  input  logic [WORD_W-1:0] sti_di,
  output logic              res_wr,
  output logic [RES_AW-1:0] res_addr,
  output logic [7:0]        res_do,
  output logic [RES_AW-1:0] obj_cnt
);

  localparam logic [RES_AW-1:0] PIX_LAST =
    RES_AW'(RES_DEPTH - 1);
  localparam logic [STI_AW-1:0] WORD_LAST =
    STI_AW'(STI_DEPTH - 1);

  ld_state_e state;
  ld_state_e state_d;

  logic [RES_AW-1:0] p;
  logic [WORD_W-1:0] word;
  logic [3:0]        k;
  logic [STI_AW-1:0] w;
  logic [6:0]        row;
  logic [6:0]        col;
  logic              border;
  logic              pix_obj;

  // p doubles as word address (high bits) and bit index (low bits)
  assign k   = p[3:0];
  assign w   = p[13:4];
  assign row = p[13:7];
  assign col = p[6:0];

  assign border = CLEAR_BORDER &&
    (row == '0 || &row || col == '0 || &col);

  assign pix_obj  = word[~k] && !border;
  assign res_addr = p;

  always_comb begin
    state_d  = state;
    busy     = 1'b0;
    done     = 1'b0;
    sti_rd   = 1'b0;
    sti_addr = '0;
    res_wr   = 1'b0;
    res_do   = '0;
    unique case (state)
      LD_IDLE: begin
        if (start) state_d = LD_FETCH;
      end
      LD_FETCH: begin
        busy    = 1'b1;
        sti_rd  = 1'b1;
        state_d = LD_WRITE;
      end
      LD_WRITE: begin
        busy   = 1'b1;
        res_wr = 1'b1;
        res_do = pix_obj ? OBJ_VAL : BG_VAL;
        if (&k && w != WORD_LAST) begin
          sti_rd   = 1'b1;
          sti_addr = w + STI_AW'(1);
        end
        if (p == PIX_LAST) state_d = LD_DONE;
      end
      LD_DONE: begin
        done    = 1'b1;
        state_d = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LD_IDLE;
      p       <= '0;
      word    <= '0;
      obj_cnt <= '0;
    end else begin
      state <= state_d;
      // wraps back to 0 after the last pixel
      if (res_wr) p <= p + RES_AW'(1);
      if (sti_rd) word <= sti_di;
      if (state == LD_FETCH)
        obj_cnt <= '0;
      else if (res_wr && pix_obj && !(&obj_cnt))
        obj_cnt <= obj_cnt + RES_AW'(1);
    end
  end

endmodule

// File: tb/tb_dt_sti_loader.sv
// Bench for dt_sti_loader: ROM/RAM models, protocol monitor,
// and a per-pixel reference image built from the ROM contents.
module tb_dt_sti_loader;

  localparam int NPIX   = 16384;
  localparam int T_DONE = 16386;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;

  logic        busy1, done1, rd1, wr1;
  logic [9:0]  sa1;
  logic [15:0] di1;
  logic [13:0] ra1, oc1;
  logic [7:0]  do1;

  logic        busy0, done0, rd0, wr0;
  logic [9:0]  sa0;
  logic [15:0] di0;
  logic [13:0] ra0, oc0;
  logic [7:0]  do0;

  logic [15:0] rom  [1024];
  logic [7:0]  ram1 [NPIX];
  logic [7:0]  ram0 [NPIX];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dt_sti_loader #(.CLEAR_BORDER(1'b1)) u_cb1 (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy1), .done(done1),
    .sti_rd(rd1), .sti_addr(sa1), .sti_di(di1),
    .res_wr(wr1), .res_addr(ra1), .res_do(do1),
    .obj_cnt(oc1)
  );

  dt_sti_loader #(.CLEAR_BORDER(1'b0)) u_cb0 (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy0), .done(done0),
    .sti_rd(rd0), .sti_addr(sa0), .sti_di(di0),
    .res_wr(wr0), .res_addr(ra0), .res_do(do0),
    .obj_cnt(oc0)
  );

  // ROM data valid from the falling edge of the address cycle
  always @(negedge clk) begin
    di1 <= rom[sa1];
    di0 <= rom[sa0];
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_pix(int pix, bit cb);
    int row, col, b;
    logic [15:0] wv;
    row = pix / 128;
    col = pix % 128;
    wv  = rom[row * 8 + col / 16];
    b   = int'(wv[15 - (col % 16)]);
    if (cb && (row == 0 || row == 127 ||
               col == 0 || col == 127))
      b = 0;
    return b;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out1"},
        {busy1, done1, rd1, sa1, wr1, ra1, do1, oc1}, 0);
    chk({tag, "_out0"},
        {busy0, done0, rd0, sa0, wr0, ra0, do0, oc0}, 0);
  endtask

  task automatic chk_image(input string tag);
    int bad1, bad0, n1, n0, e1, e0;
    bad1 = 0; bad0 = 0; n1 = 0; n0 = 0;
    for (int i = 0; i < NPIX; i++) begin
      e1 = exp_pix(i, 1'b1);
      e0 = exp_pix(i, 1'b0);
      n1 += e1;
      n0 += e0;
      if (ram1[i] !== 8'(e1)) bad1++;
      if (ram0[i] !== 8'(e0)) bad0++;
    end
    if (n1 > 16383) n1 = 16383;
    if (n0 > 16383) n0 = 16383;
    chk({tag, "_img_cb1"}, bad1, 0);
    chk({tag, "_img_cb0"}, bad0, 0);
    chk({tag, "_obj_cb1"}, oc1, n1);
    chk({tag, "_obj_cb0"}, oc0, n0);
  endtask

  task automatic run_load(input string tag,
                          input bit inject,
                          input int abort_at);
    int done_cyc, nrd, nwr, e_rd, e_wr, e_bsy, e_ph;
    bit aborted;
    done_cyc = 0; nrd = 0; nwr = 0;
    e_rd = 0; e_wr = 0; e_bsy = 0; e_ph = 0;
    aborted = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      ram1[i] = 8'hAA;
      ram0[i] = 8'hAA;
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= T_DONE + 50; cyc++) begin
      @(negedge clk);
      start = inject && (cyc == 500 || cyc == T_DONE);
      if (rd1) begin
        if (int'(sa1) != nrd) e_rd++;
        nrd++;
      end
      if (wr1) begin
        if (int'(ra1) != nwr) e_wr++;
        ram1[ra1] = do1;
        nwr++;
      end
      if (wr0) ram0[ra0] = do0;
      if ((rd1 && !busy1) || (wr1 && !busy1) ||
          (rd0 && !busy0) || (wr0 && !busy0))
        e_bsy++;
      if (wr1 != (cyc >= 2 && cyc < T_DONE)) e_ph++;
      if (busy1 != (cyc < T_DONE)) e_ph++;
      if (done1 != done0 || busy1 != busy0) e_ph++;
      if (done1) done_cyc = cyc;
      if (cyc == abort_at) begin
        reset = 1'b1;
        aborted = 1'b1;
      end
      if (done1 || aborted) break;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_rd_seq"}, e_rd, 0);
    chk({tag, "_wr_seq"}, e_wr, 0);
    chk({tag, "_outside_busy"}, e_bsy, 0);
    chk({tag, "_phase"}, e_ph, 0);
    if (aborted) begin
      chk({tag, "_wr_before_rst"}, nwr, abort_at - 1);
      chk_idle_outputs({tag, "_post_rst"});
      reset = 1'b0;
    end else begin
      chk({tag, "_done_cyc"}, done_cyc, T_DONE);
      chk({tag, "_rd_cnt"}, nrd, 1024);
      chk({tag, "_wr_cnt"}, nwr, NPIX);
      chk({tag, "_busy_after"}, {busy1, busy0}, 0);
      chk({tag, "_done_after"}, {done1, done0}, 0);
      chk_image(tag);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
    run_load("zero", 1'b0, 0);

    for (int i = 0; i < 1024; i++) rom[i] = 16'hFFFF;
    run_load("ones", 1'b0, 0);
    chk("ones_cnt_cb1", oc1, 15876);
    chk("ones_cnt_cb0", oc0, 16383);

    for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
    rom[9] = 16'h8001;
    run_load("word9", 1'b1, 0);
    chk("word9_px144", ram1[144], 8'h01);
    chk("word9_px159", ram1[159], 8'h01);
    chk("word9_cnt", oc1, 2);

    for (int i = 0; i < 1024; i++)
      rom[i] = 16'($urandom);
    run_load("abort", 1'b0, 5000);

    for (int i = 0; i < 1024; i++)
      rom[i] = 16'($urandom);
    run_load("reload", 1'b0, 0);

    repeat (4) @(negedge clk);
    chk_image("idle_hold");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/dt_sti_loader.md
# dt_sti_loader

Upstream image-load stage for the distance-transform (DT) core. Reads the packed 128×128 binary source image from the 1024×16-bit `sti` ROM and unpacks it one pixel per cycle into the 16384×8-bit `res` RAM, producing the object/background map that the DT forward pass consumes. It optionally forces the one-pixel image border to background and reports the object-pixel count. It owns the `sti` ROM port and the `res` RAM write port until it asserts `done`, then releases both to the DT core.

## Interface
- `OBJ_VAL`, 8'h01: byte written for an object pixel (source bit = 1).
- `BG_VAL`, 8'h00: byte written for a background pixel.
- `CLEAR_BORDER`, 1: when 1, rows 0/127 and columns 0/127 are written as `BG_VAL` regardless of source.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to load the image; ignored unless IDLE.
- `busy`  out  1  high from FETCH through the final WRITE.
- `done`  out  1  one-cycle pulse after the last RAM write.
- `sti_rd`  out  1  ROM read enable.
- `sti_addr`  out  10  ROM word address, row*8 + col/16.
- `sti_di`  in  16  ROM data. Bit 15 is the leftmost pixel of the word.
- `res_wr`  out  1  RAM write enable.
- `res_addr`  out  14  RAM pixel address, row*128 + col.
- `res_do`  out  8  RAM write data.
- `obj_cnt`  out  14  number of `OBJ_VAL` bytes written in the current or last load. Saturates at 16383.

## Operation
- FSM states:
  - IDLE: `start` → FETCH.
  - FETCH: `sti_rd`=1, `sti_addr`=0; → WRITE.
  - WRITE: loops over 16384 pixels; after the last pixel → DONE.
  - DONE: `done`=1; → IDLE.
- Word register: loaded from `sti_di` on the rising edge that ends FETCH, and on the edge ending each pixel whose index k is 15.
- Each WRITE cycle:
  - `res_wr`=1 and `res_addr`=p, where p runs 0..16383.
  - `res_do` = `OBJ_VAL` if word bit (15−k) is 1 and p is not a border pixel (border clearing only when `CLEAR_BORDER`=1); otherwise `BG_VAL`.
- Prefetch: in the WRITE cycle with k=15 and word address w<1023, drive `sti_rd`=1 and `sti_addr`=w+1. This keeps pixel output gapless.
- `obj_cnt`:
  - cleared on the FETCH cycle.
  - incremented on each WRITE cycle whose data is `OBJ_VAL`.
  - holds its value in IDLE.
- `start` while busy or in DONE: ignored, with no effect on counters.
- Reset at any time, including mid-load:
  - state returns to IDLE and all counters clear.
  - `obj_cnt` = 0; all outputs = 0.
  - RAM contents already written are left as they are; the next `start` rewrites the entire image.
- Border detection: row = p[13:7] ∈ {0,127}, or col = p[6:0] ∈ {0,127}.

## Timing
- `start` is sampled high at edge 0. FETCH occupies cycle 1; WRITE occupies cycles 2..16385; `done` is high in cycle 16386. Total latency is 16386 cycles.
- ROM data for an address driven in cycle n becomes valid at the falling edge of cycle n and is sampled at the rising edge ending cycle n.
- RAM writes complete on the rising edge ending each WRITE cycle.
- All outputs are registered or decoded from registered state.
- Reset values: `busy`=0, `done`=0, `sti_rd`=0, `sti_addr`=0, `res_wr`=0, `res_addr`=0, `res_do`=0, `obj_cnt`=0.
- `sti_rd` is high in exactly 1024 cycles per load. `res_wr` is high in exactly 16384 consecutive cycles.

## Structure
- Shared package `dt_pkg`:
  - constants: IMG_W=128, IMG_H=128, WORD_W=16, STI_DEPTH=1024, RES_DEPTH=16384.
  - loader state enum (IDLE, FETCH, WRITE, DONE).
  - address widths (10, 14).
- Single module with no submodules. The pixel counter p (14 bits) supplies word address p[13:4] and bit index k=p[3:0], so no separate word counter is needed.

## Test plan
- All-zero ROM, `start` → 16384 writes of 8'h00, `obj_cnt`=0, `done` exactly at cycle 16386, `busy` low thereafter.
- All-ones ROM, `CLEAR_BORDER`=1 → interior bytes 8'h01, border bytes 8'h00, `obj_cnt`=15876. Same stimulus with `CLEAR_BORDER`=0 → `obj_cnt`=16383 (saturated), all bytes 8'h01.
- ROM word 9 = 16'h8001, all other words 0, `CLEAR_BORDER`=1 → `res_M[144]`=8'h01, `res_M[159]`=8'h01, all other bytes 0, `obj_cnt`=2.
- `start` pulsed again at cycles 500 and 16386 → no restart and no change to `obj_cnt`. A `start` at cycle 16388 (IDLE) → a new load begins cleanly.
- Reset asserted at cycle 5000 → the next cycle has all outputs 0 and state IDLE. A following `start` reloads the full image correctly, overwriting partial data.
- Protocol monitor over a full load:
  - `sti_addr` sequence is 0..1023, each value exactly once.
  - `res_addr` increments by 1 every write cycle.
  - `sti_rd` and `res_wr` are never asserted outside `busy`.
